hazard_fwd_ctrl: RTL

- Pipeline hazard and forwarding controller for the 5-stage core (IF/ID/EX/MEM/WB).
- Keeps its own shadow record of the destination register of the instructions in EX, MEM and WB.
- Drives the operand-forwarding selects of the ID-stage operand muxes, and generates load-use and multi-cycle-MDU stalls plus branch flushes.
- Sits beside the ID stage; its selects feed the two-source forwarding muxes for rs and rt.

---
 rtl/hazard_fwd_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding control for the 5-stage core.
// Ports: ID operand info in; fwd selects, stall, flush, mdu_busy out.
module hazard_fwd_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_rs_used,
  input  logic       id_rt_used,
  input  logic       id_wr_en,
  input  logic [4:0] id_wr_reg,
  input  logic       id_is_load,
  input  logic       id_is_mdu,
  input  logic       id_uses_hilo,
  input  logic       ex_branch_taken,
  output logic [1:0] fwd_sel_rs,
  output logic [1:0] fwd_sel_rt,
  output logic       stall,
  output logic       flush,
  output logic       mdu_busy
);

  typedef struct packed {
    logic       v;
    logic       wr;
    logic [4:0] rg;
    logic       ld;
  } ent_t;

  ent_t ex_q, ex_d;
  ent_t mem_q;
  ent_t wb_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic h_data;
  logic h_mdu;
  logic accept;

  function automatic logic hit(
    input ent_t e,
    input logic [4:0] r
  );
    return e.v & e.wr & (e.rg == r) & (r != 5'd0);
  endfunction

  assign flush    = ex_branch_taken;
  assign mdu_busy = (cnt_q != '0);

  always_comb begin
    fwd_sel_rs = 2'd0;
    if (id_rs_used & hit(mem_q, id_rs) & ~mem_q.ld)
      fwd_sel_rs = 2'd1;
    else if (id_rs_used & hit(wb_q, id_rs))
      fwd_sel_rs = 2'd2;
  end

  always_comb begin
    fwd_sel_rt = 2'd0;
    if (id_rt_used & hit(mem_q, id_rt) & ~mem_q.ld)
      fwd_sel_rt = 2'd1;
    else if (id_rt_used & hit(wb_q, id_rt))
      fwd_sel_rt = 2'd2;
  end

  // A load result is not ready until WB, so a
  // load in MEM stalls instead of forwarding.
  always_comb begin
    h_data = (id_rs_used &
              (hit(ex_q, id_rs) |
               (hit(mem_q, id_rs) & mem_q.ld))) |
             (id_rt_used &
              (hit(ex_q, id_rt) |
               (hit(mem_q, id_rt) & mem_q.ld)));
    h_mdu  = mdu_busy & (id_is_mdu | id_uses_hilo);
    stall  = id_valid & ~flush & (h_data | h_mdu);
  end

  assign accept = id_valid & ~stall & ~flush;

  always_comb begin
    ex_d = '0;
    if (accept) begin
      ex_d.v  = 1'b1;
      ex_d.wr = id_wr_en;
      ex_d.rg = id_wr_reg;
      ex_d.ld = id_is_load;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept & id_is_mdu)
      cnt_d = CNT_W'(MDU_LAT - 1);
    else if (mdu_busy)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
      cnt_q <= cnt_d;
    end
  end

endmodule
